cs_puf_chal_seq: RTL

- Challenge sequencer for the CS-PUF permutation selector (the block that turns a 16-bit permutation index into an 8-bit comparator-select word and then raises amp_enable).
- Takes one start command and runs a burst of up to MAX_CHAL challenges: index_k = (base_sel + k*stride) mod 40320.
- For each challenge it restarts the selector and waits for amp_enable. It then waits a settle time, samples the single-bit PUF response and packs it into a response word.
- Sits between the bus-side PUF register file and the selector/amplifier datapath.

---
 rtl/cs_puf_pkg.sv | 26 ++
 rtl/cs_puf_idx_step.sv | 20 ++
 rtl/cs_puf_chal_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cs_puf_pkg.sv
// Shared state encoding and permutation-space constants for the CS-PUF
// challenge sequencer and its index stepper.
package cs_puf_pkg;

    localparam int PERM_COUNT = 40320;
    localparam int PERM_IDX_W = 16;

    typedef logic [PERM_IDX_W-1:0] perm_idx_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_WAIT_AMP,
        ST_SETTLE,
        ST_SAMPLE,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic logic idx_legal(input perm_idx_t idx);
        return int'(idx) < PERM_COUNT;
    endfunction

endpackage

// File: rtl/cs_puf_idx_step.sv
// Combinational modular step: (cur + stride) mod PERM_COUNT, both operands
// already below PERM_COUNT so one conditional subtract is enough.
module cs_puf_idx_step
    import cs_puf_pkg::*;
(
    input  logic [PERM_IDX_W-1:0] cur_i,
    input  logic [PERM_IDX_W-1:0] stride_i,
    output logic [PERM_IDX_W-1:0] next_o
);

    localparam logic [PERM_IDX_W:0] PERM_COUNT_X = (PERM_IDX_W + 1)'(PERM_COUNT);

    logic [PERM_IDX_W:0] sum;
    logic [PERM_IDX_W:0] wrapped;

    assign sum     = {1'b0, cur_i} + {1'b0, stride_i};
    assign wrapped = sum - PERM_COUNT_X;
    assign next_o  = (sum >= PERM_COUNT_X) ? wrapped[PERM_IDX_W-1:0] : sum[PERM_IDX_W-1:0];

endmodule

// File: rtl/cs_puf_chal_seq.sv
// Challenge sequencer: steps a burst of permutation indices through the CS-PUF
// selector, waits for amp_enable plus a settle time, and packs response bits.
module cs_puf_chal_seq
    import cs_puf_pkg::*;
#(
    parameter int              MAX_CHAL   = 32,
    parameter int              SETTLE_CYC = 4,
    parameter int              TO_W       = 20,
    parameter logic [TO_W-1:0] TO_LIMIT   = 20'hF_FFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         base_sel,
    input  logic [15:0]         stride,
    input  logic [5:0]          num_chal,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [MAX_CHAL-1:0] resp,
    output logic [5:0]          chal_idx,
    output logic                perm_en,
    output logic [15:0]         perm_sel,
    input  logic                perm_amp_enable,
    input  logic                puf_bit
);

    localparam int               SET_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE_CYC - 1);
    localparam logic [5:0]       MAX_CHAL_6 = 6'(MAX_CHAL);

    state_e              state_q, state_d;
    logic [15:0]         stride_q, stride_d;
    logic [5:0]          num_q, num_d;
    logic [15:0]         cur_q, cur_d;
    logic [5:0]          chal_q, chal_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
    logic                clr_q, clr_d;
    logic [MAX_CHAL-1:0] resp_q, resp_d;
    logic                error_q, error_d;
    logic                busy_q, done_q, perm_en_q;
    logic [15:0]         perm_sel_q;
    logic                busy_d, done_d, perm_en_d;
    logic [15:0]         perm_sel_d;
    logic [15:0]         cur_step;
    logic                start_ok;

    cs_puf_idx_step u_idx_step (
        .cur_i    (cur_q),
        .stride_i (stride_q),
        .next_o   (cur_step)
    );

    assign start_ok = idx_legal(base_sel) && idx_legal(stride)
                   && (num_chal != 6'd0) && (num_chal <= MAX_CHAL_6);

    always_comb begin
        // NOTE: every _d holds its current value first, so no branch of the case can infer a latch.
        state_d   = state_q;
        stride_d  = stride_q;
        num_d     = num_q;
        cur_d     = cur_q;
        chal_d    = chal_q;
        to_cnt_d  = to_cnt_q;
        set_cnt_d = set_cnt_q;
        clr_d     = clr_q;
        resp_d    = resp_q;
        error_d   = error_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && start_ok) begin
                    stride_d = stride;
                    num_d    = num_chal;
                    cur_d    = base_sel;
                    chal_d   = '0;
                    resp_d   = '0;
                    error_d  = 1'b0;
                    clr_d    = 1'b0;
                    state_d  = ST_CLEAR;
                end else if (start) begin
                    error_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_q) state_d = ST_LOAD;
                else       clr_d   = 1'b1;
            end
            ST_LOAD: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT_AMP;
            end
            ST_WAIT_AMP: begin
                if (perm_amp_enable) begin
                    set_cnt_d = '0;
                    state_d   = ST_SETTLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_d == TO_LIMIT) state_d = ST_ERR;
                end
            end
            ST_SETTLE: begin
                if (!perm_amp_enable)        state_d   = ST_ERR;
                else if (set_cnt_q == SET_LAST) state_d = ST_SAMPLE;
                else                         set_cnt_d = set_cnt_q + SET_W'(1);
            end
            ST_SAMPLE: begin
                for (int i = 0; i < MAX_CHAL; i++) begin
                    if (chal_q == 6'(i)) resp_d[i] = puf_bit;
                end
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (chal_q == num_q - 6'd1) begin
                    state_d = ST_DONE;
                end else begin
                    chal_d  = chal_q + 6'd1;
                    cur_d   = cur_step;
                    clr_d   = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ERR) error_d = 1'b1;
    end

    // Outputs are decoded from the next state so they settle with the state register.
    assign busy_d     = (state_d != ST_IDLE);
    assign done_d     = (state_d == ST_DONE);
    assign perm_en_d  = (state_d inside {ST_LOAD, ST_WAIT_AMP, ST_SETTLE, ST_SAMPLE});
    assign perm_sel_d = (state_d == ST_LOAD) ? cur_d : perm_sel_q;

    // NOTE: non-blocking assignments let every register update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            stride_q   <= '0;
            num_q      <= '0;
            cur_q      <= '0;
            chal_q     <= '0;
            to_cnt_q   <= '0;
            set_cnt_q  <= '0;
            clr_q      <= 1'b0;
            resp_q     <= '0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            perm_en_q  <= 1'b0;
            perm_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            stride_q   <= stride_d;
            num_q      <= num_d;
            cur_q      <= cur_d;
            chal_q     <= chal_d;
            to_cnt_q   <= to_cnt_d;
            set_cnt_q  <= set_cnt_d;
            clr_q      <= clr_d;
            resp_q     <= resp_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            perm_en_q  <= perm_en_d;
            perm_sel_q <= perm_sel_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign resp     = resp_q;
    assign chal_idx = chal_q;
    assign perm_en  = perm_en_q;
    assign perm_sel = perm_sel_q;

endmodule
